shift_issue_stage: RTL and testbench



---
 rtl/shift_issue_stage.sv | 99 +++++++++
 tb/tb_shift_issue_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// Registered valid/ready issue stage feeding the 32-bit shifter, with a 2-entry skid buffer.
// Optional perf counters (perf_issued, perf_stall) are built when SHIFT_ISSUE_PERF_EN is defined.
//
// occupancy (m_valid,s_valid) | meaning
// 00                          | empty, accepting
// 10                          | one op presented to the shifter, accepting
// 11                          | M presented, S holds the next op, in_ready low
module shift_issue_stage #(
   parameter int TAG_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [31:0]       in_rs2,
   input  logic [4:0]        in_shamt,
   input  logic [2:0]        in_func,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [31:0]       out_rs2,
   output logic [4:0]        out_shamt,
   output logic [2:0]        out_func,
   output logic [TAG_W-1:0]  out_tag,
`ifdef SHIFT_ISSUE_PERF_EN
   output logic              out_illegal,
   output logic [31:0]       perf_issued,
   output logic [31:0]       perf_stall
`else
   output logic              out_illegal
`endif
);

   localparam int PW = DATA_W + 32 + 5 + 3 + TAG_W;

   logic          m_valid;
   logic          s_valid;
   logic [PW-1:0] m_pay;
   logic [PW-1:0] s_pay;
   logic [PW-1:0] in_pay;
   logic          accept;
   logic          deliver;

   assign in_pay   = {in_data, in_rs2, in_shamt, in_func, in_tag};
   // in_ready comes straight from the skid flop, so out_ready never reaches decode combinationally
   assign in_ready = ~s_valid;
   assign accept   = in_valid & in_ready;
   assign deliver  = m_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_pay   <= '0;
         s_pay   <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (!m_valid || deliver) begin
         if (s_valid) begin
            m_pay   <= s_pay;
            m_valid <= 1'b1;
            s_valid <= 1'b0;
         end else if (accept) begin
            m_pay   <= in_pay;
            m_valid <= 1'b1;
         end else begin
            m_valid <= 1'b0;
         end
      end else if (accept) begin
         s_pay   <= in_pay;
         s_valid <= 1'b1;
      end
   end

   assign out_valid = m_valid;
   assign {out_data, out_rs2, out_shamt, out_func, out_tag} = m_pay;
   // func codes 1xx are illegal; the op still flows so writeback can suppress it
   assign out_illegal = m_pay[TAG_W+2];

`ifdef SHIFT_ISSUE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (deliver)
            perf_issued <= perf_issued + 32'd1;
         if (m_valid && !out_ready)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: directed vector table, random streaming
// against a scoreboard, and (with SHIFT_ISSUE_PERF_EN) the perf counters.
module tb_shift_issue_stage;

   typedef struct {
      logic [31:0] data;
      logic [31:0] rs2;
      logic [4:0]  shamt;
      logic [2:0]  func;
      logic [4:0]  tag;
   } op_t;

   typedef struct {
      logic rst, flush, iv, ordy;
      op_t  op;
      logic ov, ir, chk;
      op_t  eop;
      logic eill;
      logic chk_sh;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0] in_data, in_rs2, out_data, out_rs2;
   logic [4:0]  in_shamt, in_tag, out_shamt, out_tag;
   logic [2:0]  in_func, out_func;
`ifdef SHIFT_ISSUE_PERF_EN
   logic [31:0] perf_issued, perf_stall;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   shift_issue_stage #(.TAG_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_rs2(in_rs2), .in_shamt(in_shamt),
      .in_func(in_func), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_rs2(out_rs2), .out_shamt(out_shamt),
      .out_func(out_func), .out_tag(out_tag),
`ifdef SHIFT_ISSUE_PERF_EN
      .out_illegal(out_illegal),
      .perf_issued(perf_issued), .perf_stall(perf_stall)
`else
      .out_illegal(out_illegal)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input op_t o);
      in_data  = o.data;
      in_rs2   = o.rs2;
      in_shamt = o.shamt;
      in_func  = o.func;
      in_tag   = o.tag;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_pay(input string tagname, input op_t e, input logic eill);
      check({tagname, ".data"},  out_data, e.data);
      check({tagname, ".rs2"},   out_rs2, e.rs2);
      check({tagname, ".shamt"}, 32'(out_shamt), 32'(e.shamt));
      check({tagname, ".func"},  32'(out_func), 32'(e.func));
      check({tagname, ".tag"},   32'(out_tag), 32'(e.tag));
      check({tagname, ".ill"},   32'(out_illegal), 32'(eill));
   endtask

   function automatic op_t mkop(input logic [31:0] d, input logic [31:0] r,
                                input logic [4:0] s, input logic [2:0] f, input logic [4:0] t);
      op_t o;
      o.data = d; o.rs2 = r; o.shamt = s; o.func = f; o.tag = t;
      return o;
   endfunction

   function automatic vec_t mk(input logic r, input logic fl, input logic iv, input logic ordy,
                               input op_t op, input logic ov, input logic ir, input logic chk,
                               input op_t eop, input logic eill, input logic chk_sh);
      vec_t v;
      v.rst = r; v.flush = fl; v.iv = iv; v.ordy = ordy; v.op = op;
      v.ov = ov; v.ir = ir; v.chk = chk; v.eop = eop; v.eill = eill; v.chk_sh = chk_sh;
      return v;
   endfunction

   vec_t vt[24];
   op_t  sq[100];

   initial begin
      op_t z, a, b1, b2, b3, f1, f2, f3, f4, i1;
      logic [31:0] sh;
      int idx, dl, edges;
      logic acc, del;

      z  = mkop(32'h0, 32'h0, 5'd0, 3'b000, 5'd0);
      a  = mkop(32'h8000_0001, 32'h0, 5'd4, 3'b010, 5'd7);
      b1 = mkop(32'h1111_1111, 32'h1, 5'd1, 3'b000, 5'd1);
      b2 = mkop(32'h2222_2222, 32'h0, 5'd2, 3'b001, 5'd2);
      b3 = mkop(32'h3333_3333, 32'h1, 5'd3, 3'b011, 5'd3);
      f1 = mkop(32'hAAAA_0001, 32'h5, 5'd9, 3'b001, 5'd10);
      f2 = mkop(32'hBBBB_0002, 32'h6, 5'd8, 3'b100, 5'd11);
      f3 = mkop(32'hCCCC_0003, 32'h7, 5'd7, 3'b010, 5'd12);
      f4 = mkop(32'hDDDD_0004, 32'h8, 5'd6, 3'b000, 5'd13);
      i1 = mkop(32'h1234_5678, 32'hFFFF_FFFF, 5'd31, 3'b101, 5'd31);

      //           rst fl iv or op  ov ir chk eop ill sh
      vt[0]  = mk(1, 0, 0, 0, z,  0, 1, 1, z,  0, 0);
      vt[1]  = mk(1, 0, 0, 0, z,  0, 1, 1, z,  0, 0);
      vt[2]  = mk(0, 0, 0, 1, z,  0, 1, 1, z,  0, 0);
      vt[3]  = mk(0, 0, 1, 1, a,  1, 1, 1, a,  0, 1);
      vt[4]  = mk(0, 0, 0, 1, z,  0, 1, 0, z,  0, 0);
      vt[5]  = mk(0, 0, 1, 0, b1, 1, 1, 1, b1, 0, 0);
      vt[6]  = mk(0, 0, 1, 0, b2, 1, 0, 1, b1, 0, 0);
      vt[7]  = mk(0, 0, 1, 0, b3, 1, 0, 1, b1, 0, 0);
      vt[8]  = mk(0, 0, 1, 1, b3, 1, 1, 1, b2, 0, 0);
      vt[9]  = mk(0, 0, 1, 1, b3, 1, 1, 1, b3, 0, 0);
      vt[10] = mk(0, 0, 0, 1, z,  0, 1, 0, z,  0, 0);
      vt[11] = mk(0, 0, 1, 0, f1, 1, 1, 1, f1, 0, 0);
      vt[12] = mk(0, 0, 1, 0, f2, 1, 0, 1, f1, 0, 0);
      vt[13] = mk(0, 1, 1, 0, f3, 0, 1, 0, z,  0, 0);
      vt[14] = mk(0, 0, 0, 1, z,  0, 1, 0, z,  0, 0);
      vt[15] = mk(0, 1, 1, 1, f4, 0, 1, 0, z,  0, 0);
      vt[16] = mk(0, 0, 0, 1, z,  0, 1, 0, z,  0, 0);
      vt[17] = mk(0, 0, 1, 0, i1, 1, 1, 1, i1, 1, 0);
      vt[18] = mk(0, 0, 0, 0, z,  1, 1, 1, i1, 1, 0);
      vt[19] = mk(0, 0, 0, 1, z,  0, 1, 0, z,  0, 0);
      vt[20] = mk(0, 0, 1, 0, b1, 1, 1, 1, b1, 0, 0);
      vt[21] = mk(0, 0, 1, 0, b2, 1, 0, 1, b1, 0, 0);
      vt[22] = mk(1, 0, 1, 0, b3, 0, 1, 1, z,  0, 0);
      vt[23] = mk(0, 0, 0, 1, z,  0, 1, 1, z,  0, 0);

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      drive(z);
      #2;

      for (int i = 0; i < 24; i++) begin
         rst = vt[i].rst; flush = vt[i].flush; in_valid = vt[i].iv; out_ready = vt[i].ordy;
         drive(vt[i].op);
         tick();
         check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vt[i].ov));
         check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vt[i].ir));
         if (vt[i].chk)
            check_pay($sformatf("v%0d", i), vt[i].eop, vt[i].eill);
         if (vt[i].chk_sh) begin
            sh = $signed(out_data) >>> out_shamt;
            check("srai_result", sh, 32'hF800_0000);
         end
      end

      // streaming: one accept and one delivery per cycle
      rst = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
      for (int i = 0; i < 100; i++)
         sq[i] = mkop($urandom, $urandom, 5'($urandom_range(31)), 3'($urandom_range(7)),
                      5'($urandom_range(31)));
      idx = 0; dl = 0; edges = 0;
      while (dl < 100 && edges < 300) begin
         in_valid = (idx < 100);
         drive(idx < 100 ? sq[idx] : z);
         acc = in_valid & in_ready;
         del = out_valid & out_ready;
         if (del) begin
            check_pay($sformatf("stream%0d", dl), sq[dl], sq[dl].func[2]);
            dl++;
         end
         if (acc) idx++;
         tick();
         edges++;
      end
      in_valid = 1'b0;
      check("stream_deliveries", 32'(dl), 32'd100);
      check("stream_cycles", 32'(edges), 32'd101);

`ifdef SHIFT_ISSUE_PERF_EN
      rst = 1'b1; tick(); rst = 1'b0;
      check("perf_issued_rst", perf_issued, 32'd0);
      check("perf_stall_rst", perf_stall, 32'd0);
      out_ready = 1'b0;
      in_valid = 1'b1; drive(b1); tick();
      drive(b2); tick();
      in_valid = 1'b0; tick(); tick();
      check("perf_stall_3", perf_stall, 32'd3);
      check("perf_issued_0", perf_issued, 32'd0);
      out_ready = 1'b1; tick(); tick();
      check("perf_stall", perf_stall, 32'd3);
      check("perf_issued", perf_issued, 32'd2);
      check("perf_empty", 32'(out_valid), 32'd0);
      flush = 1'b1; tick(); flush = 1'b0;
      check("perf_issued_flush", perf_issued, 32'd2);
      check("perf_stall_flush", perf_stall, 32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
